// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage -- execute stage with EX/MEM pipeline register.
//
// Runs single-cycle ALU, memory-address, branch and jump operations with a
// one-cycle latency. MUL uses an iterative shift-add unit: one multiplier bit
// per cycle, MUL_ITER cycles per product. While the multiply runs, the stage
// stalls the front end and ignores its inputs.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   valid_in, pc4_in, opcode_in instruction from ID
//   rs_val_in, rt_val_in        operands (rt is also store data)
//   rd_addr_in, imm_in          destination register, sign-extended immediate
//   branch_in, mem_read_in,
//   mem_to_reg_in, mem_write_in ID control bits
//   hazard                      combinational stall request to IF/ID
//   valid_out, addr_in,
//   addr_reg_in, write_data,
//   mem_read, mem_write,
//   mem_to_reg                  EX/MEM register contents to MEM
//   branch_taken, ex_add        one-cycle redirect pulse and target to IF
// ----------------------------------------------------------------------------
module ex_stage #(
   parameter int D_SIZE        = 32,
   parameter int ADDR_LINE_REG = 5,
   parameter int MUL_ITER      = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     valid_in,
   input  logic [31:0]              pc4_in,
   input  logic [5:0]               opcode_in,
   input  logic [31:0]              rs_val_in,
   input  logic [31:0]              rt_val_in,
   input  logic [ADDR_LINE_REG-1:0] rd_addr_in,
   input  logic [31:0]              imm_in,
   input  logic                     branch_in,
   input  logic                     mem_read_in,
   input  logic                     mem_to_reg_in,
   input  logic                     mem_write_in,
   output logic                     hazard,
   output logic                     valid_out,
   output logic [D_SIZE-1:0]        addr_in,
   output logic [ADDR_LINE_REG-1:0] addr_reg_in,
   output logic [D_SIZE-1:0]        write_data,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic                     mem_to_reg,
   output logic                     branch_taken,
   output logic [31:0]              ex_add
);

   localparam int CW = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITER - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [5:0] OP_ADD  = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_AND  = 6'h03;
   localparam logic [5:0] OP_OR   = 6'h04;
   localparam logic [5:0] OP_XOR  = 6'h05;
   localparam logic [5:0] OP_SLT  = 6'h06;
   localparam logic [5:0] OP_MUL  = 6'h07;
   localparam logic [5:0] OP_LW   = 6'h08;
   localparam logic [5:0] OP_SW   = 6'h09;
   localparam logic [5:0] OP_BEQ  = 6'h0A;
   localparam logic [5:0] OP_BNE  = 6'h0B;
   localparam logic [5:0] OP_JMP  = 6'h0C;

   // FSM and multiplier state
   logic [0:0]               state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [31:0]              mcand_q, mcand_d;
   logic [31:0]              mplier_q, mplier_d;
   logic [31:0]              acc_q, acc_d;
   logic [31:0]              cap_rt_q, cap_rt_d;
   logic [ADDR_LINE_REG-1:0] cap_rd_q, cap_rd_d;
   logic                     cap_mr_q, cap_mr_d;
   logic                     cap_mw_q, cap_mw_d;
   logic                     cap_mtr_q, cap_mtr_d;

   // EX/MEM register
   logic                     valid_q, valid_d;
   logic [D_SIZE-1:0]        addr_q, addr_d;
   logic [ADDR_LINE_REG-1:0] rd_q, rd_d;
   logic [D_SIZE-1:0]        wdata_q, wdata_d;
   logic                     mr_q, mr_d;
   logic                     mw_q, mw_d;
   logic                     mtr_q, mtr_d;
   logic                     bt_q, bt_d;
   logic [31:0]              exa_q, exa_d;

   // Single-cycle datapath
   logic [31:0] alu;
   logic [31:0] br_target;
   logic        known_op;
   logic        rs_eq_rt;
   logic [31:0] acc_step;

   assign rs_eq_rt  = (rs_val_in == rt_val_in);
   assign br_target = pc4_in + {imm_in[29:0], 2'b00};
   assign known_op  = (opcode_in <= OP_JMP) && (opcode_in != OP_MUL);

   // Accumulator after folding in the current multiplier bit; on the last
   // iteration this is the finished product.
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

   always_comb begin
      alu = 32'd0;
      case (opcode_in)
         OP_ADD:         alu = rs_val_in + rt_val_in;
         OP_ADDI:        alu = rs_val_in + imm_in;
         OP_SUB:         alu = rs_val_in - rt_val_in;
         OP_AND:         alu = rs_val_in & rt_val_in;
         OP_OR:          alu = rs_val_in | rt_val_in;
         OP_XOR:         alu = rs_val_in ^ rt_val_in;
         OP_SLT:         alu = {31'd0, $signed(rs_val_in) < $signed(rt_val_in)};
         OP_LW, OP_SW:   alu = rs_val_in + imm_in;
         default:        alu = 32'd0;  // branches, jump: no address
      endcase
   end

   // Stall while a multiply is being accepted or still has iterations left.
   // The final iteration drops the stall so ID can advance as the product
   // lands in EX/MEM.
   assign hazard = reset &&
                   (((state_q == IDLE) && valid_in && (opcode_in == OP_MUL)) ||
                    ((state_q == BUSY) && (cnt_q != CNT_LAST)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cap_rt_d  = cap_rt_q;
      cap_rd_d  = cap_rd_q;
      cap_mr_d  = cap_mr_q;
      cap_mw_d  = cap_mw_q;
      cap_mtr_d = cap_mtr_q;

      // EX/MEM defaults to a bubble every cycle
      valid_d = 1'b0;
      addr_d  = '0;
      rd_d    = '0;
      wdata_d = '0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      mtr_d   = 1'b0;
      bt_d    = 1'b0;
      exa_d   = 32'd0;

      case (state_q)
         IDLE: begin
            if (valid_in && (opcode_in == OP_MUL)) begin
               state_d   = BUSY;
               cnt_d     = '0;
               acc_d     = 32'd0;
               mcand_d   = rs_val_in;
               mplier_d  = rt_val_in;
               cap_rt_d  = rt_val_in;
               cap_rd_d  = rd_addr_in;
               cap_mr_d  = mem_read_in;
               cap_mw_d  = mem_write_in;
               cap_mtr_d = mem_to_reg_in;
            end else if (valid_in && known_op) begin
               valid_d = 1'b1;
               addr_d  = alu[D_SIZE-1:0];
               rd_d    = rd_addr_in;
               wdata_d = rt_val_in[D_SIZE-1:0];
               mr_d    = mem_read_in;
               mw_d    = mem_write_in;
               mtr_d   = mem_to_reg_in;
               case (opcode_in)
                  OP_BEQ: begin
                     exa_d = br_target;
                     bt_d  = branch_in && rs_eq_rt;
                  end
                  OP_BNE: begin
                     exa_d = br_target;
                     bt_d  = branch_in && !rs_eq_rt;
                  end
                  OP_JMP: begin
                     exa_d = {imm_in[29:0], 2'b00};
                     bt_d  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         BUSY: begin
            // Inputs are ignored here; ID is held by hazard.
            acc_d    = acc_step;
            mcand_d  = {mcand_q[30:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               valid_d = 1'b1;
               addr_d  = acc_step[D_SIZE-1:0];
               rd_d    = cap_rd_q;
               wdata_d = cap_rt_q[D_SIZE-1:0];
               mr_d    = cap_mr_q;
               mw_d    = cap_mw_q;
               mtr_d   = cap_mtr_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mcand_q   <= 32'd0;
         mplier_q  <= 32'd0;
         acc_q     <= 32'd0;
         cap_rt_q  <= 32'd0;
         cap_rd_q  <= '0;
         cap_mr_q  <= 1'b0;
         cap_mw_q  <= 1'b0;
         cap_mtr_q <= 1'b0;
         valid_q   <= 1'b0;
         addr_q    <= '0;
         rd_q      <= '0;
         wdata_q   <= '0;
         mr_q      <= 1'b0;
         mw_q      <= 1'b0;
         mtr_q     <= 1'b0;
         bt_q      <= 1'b0;
         exa_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cap_rt_q  <= cap_rt_d;
         cap_rd_q  <= cap_rd_d;
         cap_mr_q  <= cap_mr_d;
         cap_mw_q  <= cap_mw_d;
         cap_mtr_q <= cap_mtr_d;
         valid_q   <= valid_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         wdata_q   <= wdata_d;
         mr_q      <= mr_d;
         mw_q      <= mw_d;
         mtr_q     <= mtr_d;
         bt_q      <= bt_d;
         exa_q     <= exa_d;
      end
   end

   assign valid_out    = valid_q;
   assign addr_in      = addr_q;
   assign addr_reg_in  = rd_q;
   assign write_data   = wdata_q;
   assign mem_read     = mr_q;
   assign mem_write    = mw_q;
   assign mem_to_reg   = mtr_q;
   assign branch_taken = bt_q;
   assign ex_add       = exa_q;

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage -- scoreboard bench for ex_stage. Stimulus pushes hand-computed
// expected EX/MEM contents (with the cycle they must appear in); a monitor
// pops them whenever valid_out is high and checks bubbles are all-zero.
// ----------------------------------------------------------------------------
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] pc4_in;
   logic [5:0]  opcode_in;
   logic [31:0] rs_val_in, rt_val_in, imm_in;
   logic [4:0]  rd_addr_in;
   logic        branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
   logic        hazard, valid_out;
   logic [31:0] addr_in;
   logic [4:0]  addr_reg_in;
   logic [31:0] write_data;
   logic        mem_read, mem_write, mem_to_reg, branch_taken;
   logic [31:0] ex_add;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pc4_in(pc4_in),
      .opcode_in(opcode_in), .rs_val_in(rs_val_in), .rt_val_in(rt_val_in),
      .rd_addr_in(rd_addr_in), .imm_in(imm_in), .branch_in(branch_in),
      .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
      .mem_write_in(mem_write_in), .hazard(hazard), .valid_out(valid_out),
      .addr_in(addr_in), .addr_reg_in(addr_reg_in), .write_data(write_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .branch_taken(branch_taken), .ex_add(ex_add)
   );

   typedef struct {
      logic [31:0] addr;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        mr, mw, mtr, bt;
      logic [31:0] exa;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare every valid output against the scoreboard head and
   // require bubbles to be fully zero.
   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid (cycle %0d): addr_in %h, expected no output", cyc, addr_in);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency_cycle", cyc, e.cyc);
            chk("addr_in", addr_in, e.addr);
            chk("addr_reg_in", {27'd0, addr_reg_in}, {27'd0, e.rd});
            chk("write_data", write_data, e.wd);
            chk("ctrl{mr,mw,mtr,bt}", {28'd0, mem_read, mem_write, mem_to_reg, branch_taken},
                {28'd0, e.mr, e.mw, e.mtr, e.bt});
            chk("ex_add", ex_add, e.exa);
         end
      end else begin
         chk("bubble_addr_in", addr_in, 32'd0);
         chk("bubble_ex_add", ex_add, 32'd0);
         chk("bubble_write_data", write_data, 32'd0);
         chk("bubble_ctrl", {27'd0, addr_reg_in} | {28'd0, mem_read, mem_write, mem_to_reg, branch_taken},
             32'd0);
      end
   end

   task automatic send(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic br, input logic mr, input logic mtr, input logic mw);
      @(negedge clk);
      valid_in      = 1'b1;
      opcode_in     = op;
      rs_val_in     = rs;
      rt_val_in     = rt;
      imm_in        = imm;
      pc4_in        = pc4;
      rd_addr_in    = rd;
      branch_in     = br;
      mem_read_in   = mr;
      mem_to_reg_in = mtr;
      mem_write_in  = mw;
   endtask

   task automatic idle();
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic expect_out(input logic [31:0] a, input logic [4:0] rd, input logic [31:0] wd,
                             input logic mr, input logic mw, input logic mtr, input logic bt,
                             input logic [31:0] exa, input int lat);
      exp_t e;
      e.addr = a; e.rd = rd; e.wd = wd; e.mr = mr; e.mw = mw; e.mtr = mtr;
      e.bt = bt; e.exa = exa; e.cyc = cyc + lat;
      q.push_back(e);
   endtask

   initial begin
      // Reset with a MUL presented: hazard must stay low while reset is low.
      reset = 1'b0; valid_in = 1'b1; opcode_in = 6'h07; rs_val_in = 32'd3;
      rt_val_in = 32'd3; imm_in = 32'd0; pc4_in = 32'd0; rd_addr_in = 5'd1;
      branch_in = 1'b1; mem_read_in = 1'b1; mem_to_reg_in = 1'b1; mem_write_in = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_hazard", {31'd0, hazard}, 32'd0);
      chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
      chk("reset_addr_in", addr_in, 32'd0);
      reset = 1'b1;
      valid_in = 1'b0;

      // ADD 7+5 -> 12, rd 3
      send(6'h00, 32'd7, 32'd5, 32'd0, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'd12, 5'd3, 32'd5, 0, 0, 0, 0, 32'd0, 1);
      #1 chk("add_hazard", {31'd0, hazard}, 32'd0);
      // SUB 3-5 wraps
      send(6'h02, 32'd3, 32'd5, 32'd0, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'hFFFF_FFFE, 5'd4, 32'd5, 0, 0, 0, 0, 32'd0, 1);
      // ADDI 10 + (-1)
      send(6'h01, 32'd10, 32'h77, 32'hFFFF_FFFF, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'd9, 5'd5, 32'h77, 0, 0, 0, 0, 32'd0, 1);
      // AND / OR / XOR
      send(6'h03, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'hF000, 5'd6, 32'hFF00, 0, 0, 0, 0, 32'd0, 1);
      send(6'h04, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'hFFF0, 5'd7, 32'hFF00, 0, 0, 0, 0, 32'd0, 1);
      send(6'h05, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'h0FF0, 5'd8, 32'hFF00, 0, 0, 0, 0, 32'd0, 1);
      // SLT signed: -1 < 1, 1 < -1
      send(6'h06, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'd1, 5'd9, 32'd1, 0, 0, 0, 0, 32'd0, 1);
      send(6'h06, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'd0, 5'd9, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'd0, 1);
      // Unknown opcode with valid_in: bubble, nothing expected
      send(6'h3F, 32'd1, 32'd2, 32'd3, 32'd4, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1);
      idle();
      // LW / SW
      send(6'h08, 32'h100, 32'h55, 32'd4, 32'd0, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_out(32'h104, 5'd10, 32'h55, 1, 0, 1, 0, 32'd0, 1);
      send(6'h09, 32'h40, 32'hDEAD, 32'd8, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_out(32'h48, 5'd0, 32'hDEAD, 0, 1, 0, 0, 32'd0, 1);
      // Branches: taken BEQ, then a bubble to see the pulse end
      send(6'h0A, 32'd4, 32'd4, 32'd3, 32'h100, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out(32'd0, 5'd0, 32'd4, 0, 0, 0, 1, 32'h10C, 1);
      idle();
      send(6'h0A, 32'd4, 32'd5, 32'd3, 32'h100, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out(32'd0, 5'd0, 32'd5, 0, 0, 0, 0, 32'h10C, 1);
      send(6'h0B, 32'd4, 32'd5, 32'd3, 32'h100, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out(32'd0, 5'd0, 32'd5, 0, 0, 0, 1, 32'h10C, 1);
      send(6'h0A, 32'd4, 32'd4, 32'd3, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'd0, 5'd0, 32'd4, 0, 0, 0, 0, 32'h10C, 1);
      // JMP: target imm<<2, always taken
      send(6'h0C, 32'd0, 32'd0, 32'h40, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'd0, 5'd0, 32'd0, 0, 0, 0, 1, 32'h100, 1);
      idle();

      // MUL 0x00010003 * 5, result 33 cycles after acceptance
      send(6'h07, 32'h0001_0003, 32'd5, 32'd0, 32'd0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'h0005_000F, 5'd11, 32'd5, 0, 0, 0, 0, 32'd0, 33);
      #1 chk("mul_hazard_accept", {31'd0, hazard}, 32'd1);
      // ADDs offered while busy must be ignored
      for (int k = 1; k <= 32; k++) begin
         send(6'h00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
         #1 chk($sformatf("mul_hazard_c%0d", k), {31'd0, hazard}, {31'd0, k < 32});
      end
      // Back-to-back MUL in the cycle after completion: (-1)*(-1) low word = 1
      send(6'h07, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_out(32'd1, 5'd12, 32'hFFFF_FFFF, 0, 0, 1, 0, 32'd0, 33);
      #1 chk("mul2_hazard_accept", {31'd0, hazard}, 32'd1);
      repeat (33) idle();

      // Reset during MUL iteration 10: no product, next ADD normal
      send(6'h07, 32'd3, 32'd3, 32'd0, 32'd0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (10) idle();
      @(negedge clk);
      #1 chk("busy_hazard_before_reset", {31'd0, hazard}, 32'd1);
      reset = 1'b0;
      #1 chk("hazard_in_reset", {31'd0, hazard}, 32'd0);
      @(negedge clk);
      #1;
      chk("post_reset_valid_out", {31'd0, valid_out}, 32'd0);
      chk("post_reset_addr_in", addr_in, 32'd0);
      chk("post_reset_ex_add", ex_add, 32'd0);
      chk("post_reset_hazard", {31'd0, hazard}, 32'd0);
      reset = 1'b1;
      send(6'h00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out(32'd2, 5'd1, 32'd1, 0, 0, 0, 0, 32'd0, 1);
      #1 chk("add_after_reset_hazard", {31'd0, hazard}, 32'd0);

      // Drain; anything left in the scoreboard never appeared
      repeat (40) idle();
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
